// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - game FSM encodings and board controller state codes
package game_pkg;

  typedef enum logic [3:0] {
    INICIO         = 4'd0,
    TURNO_JUGADOR  = 4'd5,
    UNA_CARTA      = 4'd6,
    DOS_CARTAS     = 4'd7,
    MOSTRAR_RANDOM = 4'd8
  } state_t;

  localparam int IDX_W = 4;

  typedef logic [2:0] ctrl_state_t;
  localparam ctrl_state_t ST_IDLE      = 3'd0;
  localparam ctrl_state_t ST_ONE       = 3'd1;
  localparam ctrl_state_t ST_TWO       = 3'd2;
  localparam ctrl_state_t ST_RAND_SCAN = 3'd3;
  localparam ctrl_state_t ST_CHECK     = 3'd4;
  localparam ctrl_state_t ST_HOLD      = 3'd5;
  localparam ctrl_state_t ST_DONE      = 3'd6;

endpackage

// File: rtl/card_board_ctrl_if.sv
// rtl/card_board_ctrl_if.sv - board controller bus: game state, symbols, selection, pulses, masks
interface card_board_ctrl_if #(
  parameter int N_CARDS = 16,
  parameter int SYM_W   = 3
);
  logic [3:0]                     game_state;
  logic [N_CARDS*SYM_W-1:0]       board_syms;
  logic                           sel_valid;
  logic [$clog2(N_CARDS)-1:0]     sel_idx;
  logic                           se_eligio_carta;
  logic                           carta_randomizada;
  logic                           cartas_verificadas;
  logic                           hubo_pareja;
  logic [N_CARDS-1:0]             revealed;
  logic [N_CARDS-1:0]             matched;
  logic [$clog2(N_CARDS)-1:0]     matched_pairs;

  modport master (
    output game_state, board_syms, sel_valid, sel_idx,
    input  se_eligio_carta, carta_randomizada, cartas_verificadas, hubo_pareja,
    input  revealed, matched, matched_pairs
  );

  modport slave (
    input  game_state, board_syms, sel_valid, sel_idx,
    output se_eligio_carta, carta_randomizada, cartas_verificadas, hubo_pareja,
    output revealed, matched, matched_pairs
  );
endinterface

// File: rtl/random_card_picker.sv
// rtl/random_card_picker.sv - scans for the next free card from a start index.
// RANDOM_LFSR_EN selects an LFSR-derived start index; otherwise the scan starts at 0.
module random_card_picker #(
  parameter int         N_CARDS   = 16,
  parameter logic [7:0] LFSR_SEED = 8'hA5
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start_i,
  input  logic                       abort_i,
  input  logic [N_CARDS-1:0]         excl_i,
  output logic                       busy_o,
  output logic                       done_o,
  output logic                       found_o,
  output logic [$clog2(N_CARDS)-1:0] idx_o
);
  localparam int IW = $clog2(N_CARDS);

  logic [IW-1:0] start_idx;
  logic [IW-1:0] ptr_q;
  logic [IW-1:0] steps_q;
  logic [IW-1:0] idx_q;
  logic          busy_q, done_q, found_q;

  // A zero seed would lock the LFSR at zero forever.
  if (LFSR_SEED == 8'h00) begin : g_zero_seed_invalid
  end

`ifdef RANDOM_LFSR_EN
  logic [7:0] lfsr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr_q <= LFSR_SEED;
    else        lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  end

  assign start_idx = lfsr_q[IW-1:0];
`else
  assign start_idx = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      found_q <= 1'b0;
      ptr_q   <= '0;
      steps_q <= '0;
      idx_q   <= '0;
    end else begin
      done_q <= 1'b0;
      if (abort_i) begin
        busy_q <= 1'b0;
      end else if (start_i) begin
        busy_q  <= 1'b1;
        ptr_q   <= start_idx;
        steps_q <= '0;
      end else if (busy_q) begin
        if (!excl_i[ptr_q]) begin
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          found_q <= 1'b1;
          idx_q   <= ptr_q;
        end else if (steps_q == IW'(N_CARDS - 1)) begin
          // Whole board excluded: give up after one lap.
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          found_q <= 1'b0;
          idx_q   <= ptr_q;
        end else begin
          ptr_q   <= ptr_q + IW'(1);
          steps_q <= steps_q + IW'(1);
        end
      end
    end
  end

  assign busy_o  = busy_q;
  assign done_o  = done_q;
  assign found_o = found_q;
  assign idx_o   = idx_q;
endmodule

// File: rtl/card_board_ctrl.sv
// rtl/card_board_ctrl.sv - memory game board controller: selections, random fill, pair check.
// Optional RANDOM_LFSR_EN randomizes the picker start index.
module card_board_ctrl
  import game_pkg::*;
#(
  parameter int         N_CARDS     = 16,
  parameter int         SYM_W       = 3,
  parameter int         HOLD_CYCLES = 50_000_000,
  parameter logic [7:0] LFSR_SEED   = 8'hA5
) (
  input logic               clk,
  input logic               rst_n,
  card_board_ctrl_if.slave  bus
);
  localparam int IW = $clog2(N_CARDS);
  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

  ctrl_state_t        state_q, state_d;
  logic [N_CARDS-1:0] revealed_q, revealed_d;
  logic [N_CARDS-1:0] matched_q, matched_d;
  logic [IW-1:0]      pairs_q, pairs_d;
  logic [IW-1:0]      first_q, first_d;
  logic [IW-1:0]      second_q, second_d;
  logic [HW-1:0]      hold_q, hold_d;
  logic               hubo_q, hubo_d;
  logic               need2_q, need2_d;
  logic               same_q, same_d;
  logic               se_q, se_d;
  logic               rand_q, rand_d;
  logic               ver_q, ver_d;

  logic               pick_start, pick_abort, pick_busy, pick_done, pick_found;
  logic [IW-1:0]      pick_idx;
  logic [N_CARDS-1:0] excl;
  logic               player_turn;
  logic [SYM_W-1:0]   syms [N_CARDS];

  for (genvar g = 0; g < N_CARDS; g++) begin : g_sym
    assign syms[g] = bus.board_syms[g*SYM_W +: SYM_W];
  end

  assign excl        = revealed_q | matched_q;
  assign player_turn = (bus.game_state == TURNO_JUGADOR) || (bus.game_state == UNA_CARTA);

  random_card_picker #(
    .N_CARDS   (N_CARDS),
    .LFSR_SEED (LFSR_SEED)
  ) u_picker (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (pick_start),
    .abort_i (pick_abort),
    .excl_i  (excl),
    .busy_o  (pick_busy),
    .done_o  (pick_done),
    .found_o (pick_found),
    .idx_o   (pick_idx)
  );

  always_comb begin
    state_d    = state_q;
    revealed_d = revealed_q;
    matched_d  = matched_q;
    pairs_d    = pairs_q;
    first_d    = first_q;
    second_d   = second_q;
    hold_d     = hold_q;
    hubo_d     = hubo_q;
    need2_d    = need2_q;
    same_d     = same_q;
    se_d       = 1'b0;
    rand_d     = 1'b0;
    ver_d      = 1'b0;
    pick_start = 1'b0;
    pick_abort = 1'b0;

    if (bus.game_state == INICIO) begin
      revealed_d = '0;
      matched_d  = '0;
      pairs_d    = '0;
      hubo_d     = 1'b0;
      state_d    = ST_IDLE;
      pick_abort = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE, ST_ONE: begin
          // A random request outranks any selection strobe in the same cycle.
          if (bus.game_state == MOSTRAR_RANDOM && !pick_busy) begin
            state_d    = ST_RAND_SCAN;
            need2_d    = (state_q == ST_IDLE);
            pick_start = 1'b1;
          end else if (bus.sel_valid && player_turn && !excl[bus.sel_idx]) begin
            revealed_d[bus.sel_idx] = 1'b1;
            se_d = 1'b1;
            if (state_q == ST_IDLE) begin
              first_d = bus.sel_idx;
              state_d = ST_ONE;
            end else begin
              second_d = bus.sel_idx;
              state_d  = ST_TWO;
            end
          end
        end
        ST_RAND_SCAN: begin
          if (pick_done) begin
            if (pick_found) revealed_d[pick_idx] = 1'b1;
            if (need2_q) begin
              first_d    = pick_idx;
              need2_d    = 1'b0;
              pick_start = 1'b1;
            end else begin
              second_d = pick_idx;
              rand_d   = 1'b1;
              state_d  = ST_TWO;
            end
          end
        end
        ST_TWO: begin
          if (bus.game_state == DOS_CARTAS) begin
            same_d  = (syms[first_q] == syms[second_q]);
            state_d = ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (same_q) begin
            matched_d[first_q]   = 1'b1;
            matched_d[second_q]  = 1'b1;
            revealed_d[first_q]  = 1'b0;
            revealed_d[second_q] = 1'b0;
            pairs_d = pairs_q + IW'(1);
            hubo_d  = 1'b1;
            ver_d   = 1'b1;
            state_d = ST_DONE;
          end else begin
            hold_d  = '0;
            state_d = ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (hold_q == HOLD_LAST) begin
            revealed_d[first_q]  = 1'b0;
            revealed_d[second_q] = 1'b0;
            hubo_d  = 1'b0;
            ver_d   = 1'b1;
            state_d = ST_DONE;
          end else begin
            hold_d = hold_q + HW'(1);
          end
        end
        ST_DONE: begin
          if (bus.game_state != DOS_CARTAS) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      revealed_q <= '0;
      matched_q  <= '0;
      pairs_q    <= '0;
      first_q    <= '0;
      second_q   <= '0;
      hold_q     <= '0;
      hubo_q     <= 1'b0;
      need2_q    <= 1'b0;
      same_q     <= 1'b0;
      se_q       <= 1'b0;
      rand_q     <= 1'b0;
      ver_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      revealed_q <= revealed_d;
      matched_q  <= matched_d;
      pairs_q    <= pairs_d;
      first_q    <= first_d;
      second_q   <= second_d;
      hold_q     <= hold_d;
      hubo_q     <= hubo_d;
      need2_q    <= need2_d;
      same_q     <= same_d;
      se_q       <= se_d;
      rand_q     <= rand_d;
      ver_q      <= ver_d;
    end
  end

  assign bus.se_eligio_carta    = se_q;
  assign bus.carta_randomizada  = rand_q;
  assign bus.cartas_verificadas = ver_q;
  assign bus.hubo_pareja        = hubo_q;
  assign bus.revealed           = revealed_q;
  assign bus.matched            = matched_q;
  assign bus.matched_pairs      = pairs_q;
endmodule

// File: tb/tb_card_board_ctrl.sv
// tb/tb_card_board_ctrl.sv - directed bench for card_board_ctrl, default build, HOLD_CYCLES=4
module tb_card_board_ctrl;
  import game_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   n_vec  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  card_board_ctrl_if #(.N_CARDS(16), .SYM_W(3)) bus ();

  card_board_ctrl #(
    .N_CARDS     (16),
    .SYM_W       (3),
    .HOLD_CYCLES (4),
    .LFSR_SEED   (8'hA5)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_sym(input int i, input logic [2:0] v);
    bus.board_syms[i*3 +: 3] = v;
  endtask

  task automatic select(input logic [3:0] idx);
    bus.sel_valid = 1'b1;
    bus.sel_idx   = idx;
    tick;
    bus.sel_valid = 1'b0;
  endtask

  task automatic wait_rand(output bit got, output logic [15:0] rev);
    got = 1'b0;
    rev = '0;
    for (int i = 0; i < 40 && !got; i++) begin
      tick;
      if (bus.carta_randomizada) begin
        got = 1'b1;
        rev = bus.revealed;
      end
    end
  endtask

  initial begin
    bit          got;
    logic [15:0] rev;
    int          extra;

    rst_n          = 1'b0;
    bus.game_state = INICIO;
    bus.board_syms = '0;
    bus.sel_valid  = 1'b0;
    bus.sel_idx    = '0;
    tick;
    tick;
    rst_n = 1'b1;
    tick;
    check("rst_revealed", 32'(bus.revealed), 32'h0);
    check("rst_matched",  32'(bus.matched), 32'h0);
    check("rst_pairs",    32'(bus.matched_pairs), 32'h0);
    check("rst_hubo",     32'(bus.hubo_pareja), 32'h0);
    check("rst_se",       32'(bus.se_eligio_carta), 32'h0);

    // Selection: 3, 3 again (rejected), 7
    set_sym(3, 3'd5);
    set_sym(7, 3'd5);
    bus.game_state = TURNO_JUGADOR;
    select(4'd3);
    check("sel3_pulse", 32'(bus.se_eligio_carta), 32'h1);
    select(4'd3);
    check("sel3_again_nopulse", 32'(bus.se_eligio_carta), 32'h0);
    select(4'd7);
    check("sel7_pulse", 32'(bus.se_eligio_carta), 32'h1);
    tick;
    check("sel7_pulse_width", 32'(bus.se_eligio_carta), 32'h0);
    check("sel_revealed", 32'(bus.revealed), 32'h0088);

    // Match 3/7
    bus.game_state = DOS_CARTAS;
    tick;
    check("match_cyc1_nopulse", 32'(bus.cartas_verificadas), 32'h0);
    tick;
    check("match_cyc2_pulse", 32'(bus.cartas_verificadas), 32'h1);
    check("match_hubo",       32'(bus.hubo_pareja), 32'h1);
    check("match_matched",    32'(bus.matched), 32'h0088);
    check("match_revealed",   32'(bus.revealed), 32'h0);
    check("match_pairs",      32'(bus.matched_pairs), 32'h1);
    tick;
    check("match_pulse_width", 32'(bus.cartas_verificadas), 32'h0);
    bus.game_state = TURNO_JUGADOR;
    tick;

    // Mismatch 1/4
    set_sym(1, 3'd2);
    set_sym(4, 3'd6);
    select(4'd1);
    select(4'd4);
    check("mis_revealed_pre", 32'(bus.revealed), 32'h0012);
    bus.game_state = DOS_CARTAS;
    for (int k = 1; k <= 5; k++) begin
      tick;
      check($sformatf("mis_cyc%0d_nopulse", k), 32'(bus.cartas_verificadas), 32'h0);
    end
    tick;
    check("mis_cyc6_pulse", 32'(bus.cartas_verificadas), 32'h1);
    check("mis_hubo",       32'(bus.hubo_pareja), 32'h0);
    check("mis_revealed",   32'(bus.revealed), 32'h0);
    check("mis_matched",    32'(bus.matched), 32'h0088);
    bus.game_state = TURNO_JUGADOR;
    tick;

    // INICIO clears the board
    bus.game_state = INICIO;
    tick;
    check("inicio_matched", 32'(bus.matched), 32'h0);
    check("inicio_pairs",   32'(bus.matched_pairs), 32'h0);

    // Build matched=0x0003, then select card 2 and fill randomly
    bus.game_state = TURNO_JUGADOR;
    set_sym(0, 3'd1);
    set_sym(1, 3'd1);
    select(4'd0);
    select(4'd1);
    bus.game_state = DOS_CARTAS;
    tick;
    tick;
    check("pre_matched_03", 32'(bus.matched), 32'h0003);
    bus.game_state = TURNO_JUGADOR;
    tick;
    select(4'd2);
    check("part_revealed_pre", 32'(bus.revealed), 32'h0004);
    bus.game_state = MOSTRAR_RANDOM;
    wait_rand(got, rev);
    check("part_rand_seen",  32'(got), 32'h1);
    check("part_revealed",   32'(rev), 32'h000C);
    check("part_state_two",  32'(dut.state_q), 32'(ST_TWO));
    extra = 0;
    repeat (20) begin
      tick;
      if (bus.carta_randomizada) extra++;
    end
    check("part_rand_single", 32'(extra), 32'h0);

    // Match 2/3 -> matched=0x000F, then full random fill
    set_sym(2, 3'd3);
    set_sym(3, 3'd3);
    bus.game_state = DOS_CARTAS;
    tick;
    tick;
    check("pre_matched_0f", 32'(bus.matched), 32'h000F);
    check("pre_pairs_2",    32'(bus.matched_pairs), 32'h2);
    bus.game_state = TURNO_JUGADOR;
    tick;
    bus.game_state = MOSTRAR_RANDOM;
    wait_rand(got, rev);
    check("full_rand_seen", 32'(got), 32'h1);
    check("full_revealed",  32'(rev), 32'h0030);
    extra = 0;
    repeat (20) begin
      tick;
      if (bus.carta_randomizada) extra++;
    end
    check("full_rand_single", 32'(extra), 32'h0);
    check("full_state_two",   32'(dut.state_q), 32'(ST_TWO));

    // Mismatch 4/5, asynchronous reset while holding
    set_sym(4, 3'd0);
    set_sym(5, 3'd7);
    bus.game_state = DOS_CARTAS;
    tick;
    tick;
    tick;
    rst_n = 1'b0;
    #1;
    check("arst_revealed", 32'(bus.revealed), 32'h0);
    check("arst_matched",  32'(bus.matched), 32'h0);
    check("arst_pairs",    32'(bus.matched_pairs), 32'h0);
    check("arst_hubo",     32'(bus.hubo_pareja), 32'h0);
    check("arst_ver",      32'(bus.cartas_verificadas), 32'h0);
    tick;
    tick;
    rst_n = 1'b1;
    extra = 0;
    repeat (10) begin
      tick;
      if (bus.cartas_verificadas) extra++;
    end
    check("arst_no_ver_after", 32'(extra), 32'h0);
    check("arst_revealed_after", 32'(bus.revealed), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
